// File: rtl/rvb_simple_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : rvb_simple_dispatch
// Brief    : Instruction feeder for rvb_simple. It classifies the opcode, folds
//            the immediate into rs2, and queues results in a 2-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rvb_simple_dispatch #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_rs3,
    output logic            out_insn3,
    output logic            out_insn5,
    output logic            out_insn12,
    output logic            out_insn13,
    output logic            out_insn14,
    output logic            out_insn25,
    output logic            out_insn26,
    output logic            out_insn27,
    output logic            out_insn30,
    output logic            err_valid,
    output logic [31:0]     err_insn,
    output logic [15:0]     err_count
);

    localparam int         c_ENTRY_W    = 3 * XLEN + 9;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP32   = 7'b0111011;
    localparam logic [6:0] c_OPC_OPIMM32 = 7'b0011011;

    logic [c_ENTRY_W-1:0] r_mem [0:1];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;
    logic                 r_in_ready;
    logic                 r_err_valid;
    logic [31:0]          r_err_insn;
    logic [15:0]          r_err_count;

    logic [6:0]           w_opcode;
    logic                 w_supported;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_out_valid;
    logic [XLEN-1:0]      w_imm;
    logic [XLEN-1:0]      w_rs2_eff;
    logic [c_ENTRY_W-1:0] w_wdata;
    logic [c_ENTRY_W-1:0] w_head;
    logic [1:0]           w_count_nxt;

    assign w_opcode    = in_insn[6:0];
    assign w_supported = (w_opcode == c_OPC_OP) || (w_opcode == c_OPC_OPIMM) ||
                         ((XLEN == 64) && ((w_opcode == c_OPC_OP32) ||
                                           (w_opcode == c_OPC_OPIMM32)));

    // A drop still consumes the handshake but never occupies a slot.
    assign w_accept    = in_valid && r_in_ready;
    assign w_push      = w_accept && w_supported;
    assign w_drop      = w_accept && !w_supported;
    assign w_out_valid = (r_count != 2'd0);
    assign w_pop       = w_out_valid && out_ready;

    assign w_imm     = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};
    assign w_rs2_eff = in_insn[5] ? in_rs2 : w_imm;
    assign w_wdata   = {in_rs1, w_rs2_eff, in_rs3,
                        in_insn[3],  in_insn[5],  in_insn[12],
                        in_insn[13], in_insn[14], in_insn[25],
                        in_insn[26], in_insn[27], in_insn[30]};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_valid <= 1'b0;
            r_err_insn  <= 32'd0;
            r_err_count <= 16'd0;
        end else begin
            r_err_valid <= w_drop;
            if (w_drop) begin
                r_err_insn <= in_insn;
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign in_ready   = r_in_ready;
    assign out_valid  = w_out_valid;
    assign out_rs1    = w_head[3*XLEN+8 : 2*XLEN+9];
    assign out_rs2    = w_head[2*XLEN+8 : XLEN+9];
    assign out_rs3    = w_head[XLEN+8 : 9];
    assign out_insn3  = w_head[8];
    assign out_insn5  = w_head[7];
    assign out_insn12 = w_head[6];
    assign out_insn13 = w_head[5];
    assign out_insn14 = w_head[4];
    assign out_insn25 = w_head[3];
    assign out_insn26 = w_head[2];
    assign out_insn27 = w_head[1];
    assign out_insn30 = w_head[0];
    assign err_valid  = r_err_valid;
    assign err_insn   = r_err_insn;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/rvb_simple_dispatch.md
Name: rvb_simple_dispatch

Overview:
- Upstream feeder for rvb_simple.
- Accepts full 32-bit instruction words with register operands over a valid/ready handshake.
- Classifies the opcode, substitutes the immediate into rs2 for immediate forms, and extracts the instruction bits rvb_simple consumes (insn3/5/12/13/14/25/26/27/30).
- Presents results through a 2-entry FIFO, so in_ready is a registered signal. Unsupported opcodes are dropped and reported on an error side channel.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  block can accept; registered, equals !full.
- in_insn  input  32  raw instruction word.
- in_rs1  input  XLEN  rs1 value.
- in_rs2  input  XLEN  rs2 value; ignored for immediate forms.
- in_rs3  input  XLEN  rs3 value.
- out_valid  output  1  entry available to rvb_simple (connects to din_valid).
- out_ready  input  1  rvb_simple din_ready.
- out_rs1, out_rs2, out_rs3  output  XLEN each  operands to rvb_simple.
- out_insn3, out_insn5, out_insn12, out_insn13, out_insn14, out_insn25, out_insn26, out_insn27, out_insn30  output  1 each  copies of the corresponding in_insn bits.
- err_valid  output  1  one-cycle pulse: an unsupported instruction was dropped.
- err_insn  output  32  instruction word of the most recent drop; holds its value.
- err_count  output  16  saturating count of dropped instructions.

Behaviour:
- Reset (async assert, sync release): FIFO emptied.
  - Outputs: in_ready=0 while reset is high, then 1 on the first clock after release. out_valid=0, err_valid=0, err_insn=0, err_count=0.
  - Data outputs are 0.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready.
- Supported opcodes (in_insn[6:0]):
  - 0110011 (OP) and 0010011 (OP-IMM).
  - 0111011 (OP-32) and 0011011 (OP-IMM-32), only when XLEN==64.
- Classification of an accepted word:
  - Supported: write to FIFO tail. rs2_eff = in_rs2 when in_insn[5]==1. Otherwise rs2_eff = in_insn[31:20] sign-extended to XLEN. Bits are copied verbatim.
  - Unsupported: nothing written. Next cycle: err_valid=1, err_insn=word, err_count+=1 (saturating at 0xFFFF).
  - The same cycle's in_ready is unaffected by a drop.
- Latency: accept at edge N, entry visible with out_valid=1 after edge N (one-cycle latency). Sustained throughput is one per cycle when out_ready is held at 1.
- Pop: occurs on an edge with out_valid && out_ready. The head advances and output fields are driven from the new head.
- Outputs are stable: while out_valid && !out_ready, all out_* are held unchanged.
- Order: strictly FIFO; drops never reorder survivors.
- Occupancy:
  - count in {0,1,2}. in_ready = (count<2), registered from next-state count.
  - Push and pop on the same edge leaves count unchanged; legal at count 1.
  - At count 2 no push is possible. A pop at count 2 makes in_ready=1 for the next cycle.
  - A dropped word counts as accepted but does not change count.
- Pointers: 1-bit read/write pointers wrap 1->0.
- XLEN==32: OP-32/OP-IMM-32 are unsupported, so out_insn3 is always 0 for forwarded words. Upper immediate bits are truncated to 32.
- Reset mid-operation: the async clear discards FIFO contents and pending err pulses immediately. out_valid drops in the same cycle reset asserts.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

Test Plan:
- XLEN=32, reset then a single word: insn=0x60051513 (OP-IMM, imm=0x600), rs1=0x12345678 -> out_valid one cycle after accept.
  - Required outputs: out_rs2=0x00000600, out_rs1=0x12345678, out_insn5=0, out_insn12=1, out_insn30=1, out_insn26=0.
  - Sign extension: imm=0xFFF gives out_rs2=0xFFFFFFFF.
- Back-pressure: out_ready=0, push three OP words (0x20B51533, 0x40B55533, 0x00B51533) -> first two accepted, in_ready=0 after the second.
  - Raise out_ready: outputs appear in order, and the third word is accepted one cycle after the first pop.
- Drop path: push insn=0x00000003 (LOAD) -> no out_valid, err_valid pulses one cycle, err_insn=0x00000003, err_count=1.
  - Interleave a drop between two OP words: only the two OP words emerge, in order.
- XLEN=64:
  - insn=0x0805153B (OP-32) -> forwarded with out_insn3=1, out_insn5=1.
  - The same word at XLEN=32 -> dropped, err_count increments.
- Random stress: 1000 words with random valid (75%) and random out_ready (87%) -> every supported word is seen exactly once, in order, with matching fields. err_count equals the number of unsupported words, and no out_* field changes while out_valid && !out_ready.
- Reset at count=2 -> out_valid=0 immediately. After release, count=0 and in_ready=1 on the first clock; no stale entry emerges.
